// File: rtl/pcpi_m_frontend.sv
// pcpi_m_frontend: PCPI front end for the M-extension unit. It decodes MUL/DIV
// requests, holds the operands stable for the unit and returns the result. A
// one-entry result cache answers an exact repeat of the last instruction.
// Latency: on a miss m_valid rises one cycle after acceptance and pcpi_ready
// follows one cycle after m_ready. On a hit pcpi_ready rises one cycle after
// acceptance.
// Flow control: pcpi_wait is held while the unit runs. After the response the
// block waits for pcpi_valid to drop before it accepts another request.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   pcpi_valid/insn/rs1/rs2          request from the CPU
//   pcpi_wr/rd/wait/ready            response to the CPU (all registered)
//   flush                            invalidate the result cache
//   m_valid/insn/rs1/rs2             start pulse and held operands to the M unit
//   m_ready/wr/rd                    completion from the M unit (m_wr unused)
module pcpi_m_frontend #(
    parameter bit         CACHE_EN = 1'b1,
    parameter logic [6:0] OPCODE_M = 7'b0110011,
    parameter logic [6:0] FUNCT7_M = 7'b0000001
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,
    input  logic        flush,
    output logic        m_valid,
    output logic [31:0] m_insn,
    output logic [31:0] m_rs1,
    output logic [31:0] m_rs2,
    input  logic        m_ready,
    input  logic        m_wr,
    input  logic [31:0] m_rd
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RESP    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int TAG_W = 3 + 32 + 32;

    state_t             state;
    logic               aborted;
    logic               cache_vld;
    logic [TAG_W-1:0]   cache_tag;
    logic [31:0]        cache_dat;

    logic               req_dec;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   run_tag;
    logic               cache_match;
    logic               req_gone;

    // Every completed instruction writes rd, so the unit's write enable is not needed.
    logic unused_m_wr;
    assign unused_m_wr = m_wr;

    assign req_dec = pcpi_valid
                  && (pcpi_insn[6:0]   == OPCODE_M)
                  && (pcpi_insn[31:25] == FUNCT7_M);

    // funct3 is part of the tag, so MUL and MULH with the same operands are
    // stored as separate entries.
    assign req_tag = {pcpi_insn[14:12], pcpi_rs1, pcpi_rs2};
    assign run_tag = {m_insn[14:12], m_rs1, m_rs2};

    // A flush that arrives together with a request takes effect before the
    // lookup, so the request misses.
    assign cache_match = CACHE_EN && cache_vld && !flush && (req_tag == cache_tag);

    // The CPU drops the request when it gives up or moves on. The current
    // operation still finishes, but no response is returned.
    assign req_gone = aborted || !pcpi_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            aborted    <= 1'b0;
            cache_vld  <= 1'b0;
            cache_tag  <= '0;
            cache_dat  <= '0;
            m_valid    <= 1'b0;
            m_insn     <= '0;
            m_rs1      <= '0;
            m_rs2      <= '0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b0;
        end else begin
            // These outputs are single-cycle pulses. pcpi_rd stays zero
            // except while pcpi_ready is high.
            m_valid    <= 1'b0;
            pcpi_ready <= 1'b0;
            pcpi_wr    <= 1'b0;
            pcpi_rd    <= '0;

            case (state)
                S_IDLE: begin
                    if (req_dec) begin
                        m_insn  <= pcpi_insn;
                        m_rs1   <= pcpi_rs1;
                        m_rs2   <= pcpi_rs2;
                        aborted <= 1'b0;
                        if (cache_match) begin
                            pcpi_ready <= 1'b1;
                            pcpi_wr    <= 1'b1;
                            pcpi_rd    <= cache_dat;
                            state      <= S_RESP;
                        end else begin
                            m_valid   <= 1'b1;
                            pcpi_wait <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (!pcpi_valid) begin
                        aborted <= 1'b1;
                    end
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (m_ready) begin
                        // The result is cached even when the request was
                        // abandoned, because the unit did complete the work.
                        cache_tag <= run_tag;
                        cache_dat <= m_rd;
                        cache_vld <= CACHE_EN;
                        pcpi_wait <= 1'b0;
                        if (req_gone) begin
                            state <= S_IDLE;
                        end else begin
                            pcpi_ready <= 1'b1;
                            pcpi_wr    <= 1'b1;
                            pcpi_rd    <= m_rd;
                            state      <= S_RESP;
                        end
                    end else if (!pcpi_valid) begin
                        aborted <= 1'b1;
                    end
                end

                S_RESP: begin
                    state <= S_RELEASE;
                end

                S_RELEASE: begin
                    // Accept nothing until the CPU has dropped the request it
                    // was just given an answer for.
                    if (!pcpi_valid) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    pcpi_wait <= 1'b0;
                end
            endcase

            // This is placed last so that it overrides a cache write in the
            // same cycle.
            if (flush) begin
                cache_vld <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pcpi_m_frontend.md
Name: pcpi_m_frontend

Overview:
- Sits between the PicoRV32 PCPI port and the M-extension controller/datapath.
- Decodes M-extension instructions and registers the request, holding instruction/rs1/rs2 stable for the unit's full duration.
- Issues a single-cycle start pulse to the unit, captures its result, and presents the PCPI response.
- Contains a one-entry result cache that answers an exact repeat of the last instruction without re-running the unit.

Parameters:
- CACHE_EN, 1, 1 enables the one-entry result cache; 0 forces every request to the unit.
- OPCODE_M, 7'b0110011, opcode field accepted.
- FUNCT7_M, 7'b0000001, funct7 field accepted.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- pcpi_valid  in  1  CPU request valid
- pcpi_insn  in  32  CPU instruction
- pcpi_rs1  in  32  CPU operand 1
- pcpi_rs2  in  32  CPU operand 2
- pcpi_wr  out  1  write rd
- pcpi_rd  out  32  result to CPU
- pcpi_wait  out  1  request accepted, in progress
- pcpi_ready  out  1  response valid (one-cycle pulse)
- flush  in  1  invalidate the result cache
- m_valid  out  1  start pulse to the M unit
- m_insn  out  32  registered instruction to the M unit
- m_rs1  out  32  registered operand 1
- m_rs2  out  32  registered operand 2
- m_ready  in  1  M unit result valid
- m_wr  in  1  M unit write enable
- m_rd  in  32  M unit result

Behaviour:
- Reset state (asynchronous, resetn=0):
  - state=IDLE.
  - All outputs 0; m_insn/m_rs1/m_rs2=0.
  - Cache valid bit=0; cache tag/data=0.
  - Reset mid-operation abandons the request with no response. The M unit is reset by the same resetn.
- Decode: a request is a hit for this block iff pcpi_valid=1, insn[6:0]=OPCODE_M and insn[31:25]=FUNCT7_M. Non-matching requests are ignored; all outputs stay 0.
- State machine:
  - IDLE: on a decoded request, latch insn/rs1/rs2 into m_*.
    - If CACHE_EN, cache valid, and {insn[14:12], rs1, rs2} equals the tag: load the response from the cache and go to RESP.
    - Otherwise go to ISSUE.
  - ISSUE: m_valid=1 for exactly this cycle; go to WAIT.
  - WAIT: m_* held constant. On m_ready=1:
    - Capture m_rd into the response register.
    - Write the cache: tag={funct3, rs1, rs2}, data=m_rd, valid=1.
    - Go to RESP.
  - RESP: pcpi_ready=1, pcpi_wr=1, pcpi_rd=response register; go to RELEASE.
  - RELEASE: wait for pcpi_valid=0, then go to IDLE. This prevents re-accepting a request the CPU has not yet dropped.
- Abort: if pcpi_valid falls in ISSUE or WAIT, the block still completes WAIT, writes the cache, suppresses RESP (pcpi_ready stays 0), and goes to IDLE. The M unit is never abandoned mid-division.
- pcpi_wait:
  - Registered: 1 in ISSUE and WAIT, and in the cycle after acceptance.
  - 0 in IDLE, RESP and RELEASE.
  - Asserted no later than 1 cycle after acceptance, so it is well inside the CPU's 16-cycle timeout.
- Latency, acceptance edge = cycle 0:
  - Miss: m_valid at cycle 1; pcpi_ready in the cycle after m_ready.
  - Hit: pcpi_ready at cycle 1.
- pcpi_rd is 0 whenever pcpi_ready=0.
- m_wr is ignored; every completed M instruction writes rd.
- Flush:
  - flush=1 clears the cache valid bit next edge.
  - A flush coinciding with a cache write wins, leaving the valid bit 0.
  - A flush arriving in IDLE together with a request is applied before the lookup, so the request is a miss.
- Cache tag includes funct3: MUL and MULH with the same operands are distinct entries and the second one misses.
- m_insn/m_rs1/m_rs2 change only on acceptance in IDLE.

Test Plan:
- MUL rs1=7, rs2=6; unit model returns 42 after 3 cycles -> m_valid single pulse at cycle 1; pcpi_ready=1, pcpi_wr=1, pcpi_rd=42 one cycle after m_ready; m_rs1/m_rs2 stable throughout.
- Repeat identical MUL 7,6 after RELEASE -> no m_valid; pcpi_rd=42 at cycle 1. Then MULH 7,6 -> miss, m_valid pulses.
- DIV rs1=-20, rs2=3, unit takes 35 cycles -> pcpi_wait=1 from cycle 1 until RESP; pcpi_rd=0xFFFFFFFA (-6).
- pcpi_valid held high for 2 cycles after pcpi_ready -> no second m_valid; block stays in RELEASE until valid=0.
- DIVU mid-WAIT pcpi_valid drops -> no pcpi_ready. The next identical DIVU is a cache hit; asserting flush before it forces a miss.
- resetn pulsed low during WAIT -> all outputs 0 immediately; the next MUL 2,3 completes normally with pcpi_rd=6. A non-M instruction (funct7=0) gives no response and no m_valid.
